tx_frame_fifo: RTL and testbench
================================

TX_FRAME_FIFO -- requirements
Module: tx_frame_fifo

Interface
REQ-001 SHALL have parameter AW, default 11, byte-buffer address width (depth 2**AW).
REQ-002 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port max_len, input, 14, largest accepted payload length in bytes.
REQ-005 SHALL have port wr_data, input, 8, payload byte from the producer.
REQ-006 SHALL have port wr_en, input, 1, wr_data valid; a byte transfers when wr_en & wr_ready.
REQ-007 SHALL have port wr_eof, input, 1, qualifies the last byte of a frame; meaningful only with wr_en.
REQ-008 SHALL have port wr_abort, input, 1, discards the frame currently being written.
REQ-009 SHALL have port wr_ready, output, 1, producer may transfer a byte this cycle.
REQ-010 SHALL have ports txff_dout (output, 8), txff_sof (output, 1), txff_empty (output, 1) and txff_rden (input, 1), first-word-fall-through read side toward the tx engine.
REQ-011 SHALL have ports frame_count and drop_count, output, 16 each, statistics (see Configuration).

Function
REQ-012 SHALL store each frame as a 2-byte big-endian length L (payload bytes, excluding the length field), then L payload bytes.
REQ-013 SHALL mark the first length byte of each frame with a ninth RAM bit; txff_sof SHALL equal that bit for the byte on txff_dout.
REQ-014 SHALL be store-and-forward: no byte of a frame becomes visible (txff_empty deasserted) until its length bytes are written and the frame is committed.
REQ-015 SHALL implement write FSM states W_IDLE, W_DATA, W_LEN_HI, W_LEN_LO, W_DROP.
REQ-016 W_IDLE: on the first accepted byte, reserve 2 slots at frame start, write the byte at start+2, and go to W_DATA (or to W_LEN_HI if wr_eof is also set).
REQ-017 W_DATA: write each accepted byte; on wr_eof go to W_LEN_HI.
REQ-018 W_LEN_HI and W_LEN_LO SHALL each take exactly one cycle, write L[15:8] and L[7:0] at start and start+1, and hold wr_ready low.
REQ-019 Leaving W_LEN_LO SHALL advance the commit pointer past the frame, increment frame_count, and return to W_IDLE; the frame is readable on the following cycle.
REQ-020 SHALL go to W_DROP when a byte is offered while free space is 0, when the byte count would exceed max_len, or on wr_abort; it SHALL rewind the write pointer to frame start and increment drop_count once.
REQ-021 W_DROP: wr_ready high, bytes discarded; wr_eof returns the FSM to W_IDLE.
REQ-022 wr_abort in W_IDLE SHALL have no effect; wr_abort with wr_eof in the same cycle SHALL drop the frame.
REQ-023 Free space SHALL be computed as depth-1-(wr_ptr-rd_ptr) with AW+1-bit pointers; frame start SHALL require at least 3 free slots, otherwise wr_ready is low in W_IDLE.
REQ-024 The read side SHALL prefetch so txff_dout/txff_sof are valid whenever txff_empty is low; txff_rden pops one byte, and the next byte is valid on the following cycle with no bubble.
REQ-025 txff_rden while txff_empty is high SHALL be ignored.
REQ-026 Counters SHALL wrap modulo 2**16.

Reset
REQ-027 Reset SHALL clear all pointers and counters and the prefetch valid flag, and set the FSM to W_IDLE.
REQ-028 Output values during reset: wr_ready 0, txff_empty 1, txff_sof 0, txff_dout 0, counts 0.
REQ-029 Reset mid-frame SHALL discard uncommitted and committed data; no partial frame appears after reset.

Configuration
REQ-030 Macro TX_FRAME_FIFO_STATS_EN: when defined, frame_count/drop_count are live as above; when undefined, both ports SHALL be tied to 0 and the counters omitted; FIFO behaviour is otherwise identical.

Structure
REQ-031 Write-FSM state encodings and the length-field width (16) SHALL live in package tx_frame_fifo_pkg.
REQ-032 Storage SHALL be sub-module tx_frame_fifo_ram: 2**AW x 9-bit, one write port, one registered read port.

Verification
REQ-033 Write a 60-byte frame 0x00..0x3B -> after commit, reads show sof=1 with byte 0x00, then 0x3C, then 0x00..0x3B; frame_count=1.
REQ-034 Write a 1-byte frame 0xA5 (wr_en & wr_eof in the same cycle) -> the FIFO reads out 0x00, 0x01, 0xA5; wr_ready is low for exactly 2 cycles.
REQ-035 Set max_len=64 and write 65 bytes -> nothing readable, drop_count=1; the next 64-byte frame passes intact.
REQ-036 AW=6, continuous txff_rden, write 70 bytes -> drop at the 62nd byte; txff_empty stays 1; drop_count=1.
REQ-037 Assert wr_abort after 10 bytes, then write a 20-byte frame -> only the 20-byte frame is read out (length 0x0014).
REQ-038 Write two 60-byte frames back-to-back with txff_rden held high -> 124 bytes stream with no txff_empty gap inside a frame, and sof asserted exactly twice.

Source files
------------

// File: rtl/tx_frame_fifo_pkg.sv
// Shared types for the frame FIFO: write-FSM state encoding and length-field width.
package tx_frame_fifo_pkg;

    localparam int LEN_W = 16;

    typedef enum logic [2:0] {
        W_IDLE   = 3'd0,
        W_DATA   = 3'd1,
        W_LEN_HI = 3'd2,
        W_LEN_LO = 3'd3,
        W_DROP   = 3'd4
    } wr_state_e;

endpackage

// File: rtl/tx_frame_fifo_ram.sv
// Simple dual-port byte buffer: 2**AW x 9 bits (bit 8 = start-of-frame), registered read.
module tx_frame_fifo_ram #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [8:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [8:0]    rdata
);

    logic [8:0] mem [0:(1<<AW)-1];
    logic [8:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/tx_frame_fifo.sv
// Store-and-forward TX frame FIFO: length-prefixed frames, FWFT read side.
// Optional statistics counters enabled by macro TX_FRAME_FIFO_STATS_EN.
import tx_frame_fifo_pkg::*;

module tx_frame_fifo #(
    parameter int AW = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] max_len,
    input  logic [7:0]  wr_data,
    input  logic        wr_en,
    input  logic        wr_eof,
    input  logic        wr_abort,
    output logic        wr_ready,
    output logic [7:0]  txff_dout,
    output logic        txff_sof,
    output logic        txff_empty,
    input  logic        txff_rden,
    output logic [15:0] frame_count,
    output logic [15:0] drop_count
);

    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    wr_state_e         state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              valid_q, valid_d;

    logic [PW-1:0]     free_slots;
    logic [LEN_W-1:0]  len_inc;
    logic              len_over;
    logic              wr_ready_c;
    logic              frame_inc, drop_inc;
    logic              ram_we, ram_re;
    logic [AW-1:0]     ram_waddr;
    logic [8:0]        ram_wdata, ram_rdata;
    logic              pop;

    assign free_slots = PW'(DEPTH - 1) - (wr_ptr_q - rd_ptr_q);
    assign len_inc    = len_q + LEN_W'(1);
    assign len_over   = len_inc > {2'b00, max_len};

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        len_d        = len_q;
        wr_ready_c   = 1'b0;
        frame_inc    = 1'b0;
        drop_inc     = 1'b0;
        ram_we       = 1'b0;
        ram_waddr    = wr_ptr_q[AW-1:0];
        ram_wdata    = {1'b0, wr_data};
        case (state_q)
            W_IDLE: begin
                // Need room for both length bytes plus the first payload byte.
                wr_ready_c = free_slots >= PW'(3);
                if (wr_en && wr_ready_c) begin
                    if (max_len == '0) begin
                        drop_inc = 1'b1;
                        state_d  = wr_eof ? W_IDLE : W_DROP;
                    end else begin
                        ram_we    = 1'b1;
                        ram_waddr = AW'(commit_ptr_q + PW'(2));
                        wr_ptr_d  = commit_ptr_q + PW'(3);
                        len_d     = LEN_W'(1);
                        state_d   = wr_eof ? W_LEN_HI : W_DATA;
                    end
                end
            end
            W_DATA: begin
                wr_ready_c = 1'b1;
                if (wr_abort || (wr_en && (free_slots == '0 || len_over))) begin
                    drop_inc = 1'b1;
                    wr_ptr_d = commit_ptr_q;
                    // If the offending byte is also the last one, the frame is already over.
                    state_d  = (wr_en && wr_eof) ? W_IDLE : W_DROP;
                end else if (wr_en) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    len_d    = len_inc;
                    if (wr_eof) state_d = W_LEN_HI;
                end
            end
            W_LEN_HI: begin
                ram_we    = 1'b1;
                ram_waddr = commit_ptr_q[AW-1:0];
                ram_wdata = {1'b1, len_q[15:8]};
                state_d   = W_LEN_LO;
            end
            W_LEN_LO: begin
                ram_we       = 1'b1;
                ram_waddr    = AW'(commit_ptr_q + PW'(1));
                ram_wdata    = {1'b0, len_q[7:0]};
                commit_ptr_d = wr_ptr_q;
                frame_inc    = 1'b1;
                state_d      = W_IDLE;
            end
            W_DROP: begin
                wr_ready_c = 1'b1;
                if (wr_en && wr_eof) state_d = W_IDLE;
            end
            default: state_d = W_IDLE;
        endcase
    end

    // The RAM output register doubles as the FWFT output stage.
    always_comb begin
        pop      = txff_rden & valid_q;
        ram_re   = (~valid_q | pop) & (rd_ptr_q != commit_ptr_q);
        rd_ptr_d = rd_ptr_q + PW'(ram_re);
        valid_d  = ram_re | (valid_q & ~pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= W_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            len_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            len_q        <= len_d;
            valid_q      <= valid_d;
        end
    end

    tx_frame_fifo_ram #(.AW(AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (ram_rdata)
    );

    assign wr_ready   = wr_ready_c & ~reset;
    assign txff_empty = ~valid_q;
    assign txff_dout  = valid_q ? ram_rdata[7:0] : 8'h00;
    assign txff_sof   = valid_q & ram_rdata[8];

`ifdef TX_FRAME_FIFO_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q + 16'(frame_inc);
        drop_cnt_d  = drop_cnt_q + 16'(drop_inc);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign frame_count = frame_cnt_q;
    assign drop_count  = drop_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = frame_inc ^ drop_inc;
    assign frame_count  = 16'h0000;
    assign drop_count   = 16'h0000;
`endif

endmodule

// File: tb/tb_tx_frame_fifo.sv
// Directed bench for tx_frame_fifo: a default-size instance plus an AW=6 instance for the full case.
module tb_tx_frame_fifo;

`ifdef TX_FRAME_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] max_len = 14'd2000;
    logic [7:0]  wr_data = '0;
    logic        wr_en = 1'b0, wr_eof = 1'b0, wr_abort = 1'b0;
    logic        wr_ready;
    logic [7:0]  txff_dout;
    logic        txff_sof, txff_empty;
    logic        txff_rden = 1'b0;
    logic [15:0] frame_count, drop_count;

    logic [7:0]  s_wr_data = '0;
    logic        s_wr_en = 1'b0, s_wr_eof = 1'b0;
    logic        s_wr_ready;
    logic [7:0]  s_txff_dout;
    logic        s_txff_sof, s_txff_empty;
    logic        s_txff_rden = 1'b0;
    logic [15:0] s_frame_count, s_drop_count;

    int n_chk = 0;
    int n_fail = 0;
    int exp_frames = 0;
    int exp_drops = 0;

    always #5 clk = ~clk;

    tx_frame_fifo dut (
        .clk(clk), .reset(reset), .max_len(max_len),
        .wr_data(wr_data), .wr_en(wr_en), .wr_eof(wr_eof), .wr_abort(wr_abort),
        .wr_ready(wr_ready), .txff_dout(txff_dout), .txff_sof(txff_sof),
        .txff_empty(txff_empty), .txff_rden(txff_rden),
        .frame_count(frame_count), .drop_count(drop_count)
    );

    tx_frame_fifo #(.AW(6)) dut_s (
        .clk(clk), .reset(reset), .max_len(14'd2000),
        .wr_data(s_wr_data), .wr_en(s_wr_en), .wr_eof(s_wr_eof), .wr_abort(1'b0),
        .wr_ready(s_wr_ready), .txff_dout(s_txff_dout), .txff_sof(s_txff_sof),
        .txff_empty(s_txff_empty), .txff_rden(s_txff_rden),
        .frame_count(s_frame_count), .drop_count(s_drop_count)
    );

    function automatic int ecnt(input int n);
        return STATS ? n : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic eof, input logic ab);
        int t = 0;
        while (!wr_ready && t < 2000) begin
            step(1);
            t++;
        end
        if (!wr_ready) chk("wr_ready_wait", wr_ready, 1);
        wr_data = d; wr_en = 1'b1; wr_eof = eof; wr_abort = ab;
        step(1);
        wr_en = 1'b0; wr_eof = 1'b0; wr_abort = 1'b0;
    endtask

    task automatic wr_frame(input int len, input int base);
        for (int i = 0; i < len; i++) wr_byte(8'(base + i), i == len - 1, 1'b0);
    endtask

    task automatic s_wr_byte(input logic [7:0] d, input logic eof);
        int t = 0;
        while (!s_wr_ready && t < 2000) begin
            step(1);
            t++;
        end
        if (!s_wr_ready) chk("s_wr_ready_wait", s_wr_ready, 1);
        s_wr_data = d; s_wr_en = 1'b1; s_wr_eof = eof;
        step(1);
        s_wr_en = 1'b0; s_wr_eof = 1'b0;
    endtask

    task automatic rd_byte(output logic [7:0] d, output logic s);
        int t = 0;
        while (txff_empty && t < 2000) begin
            step(1);
            t++;
        end
        if (txff_empty) chk("rd_wait", txff_empty, 0);
        d = txff_dout; s = txff_sof;
        txff_rden = 1'b1;
        step(1);
        txff_rden = 1'b0;
    endtask

    task automatic rd_frame(input int len, input int base, input string tag);
        logic [7:0] d;
        logic       s;
        int         psof = 0;
        rd_byte(d, s);
        chk({tag, "_sof_hi"}, s, 1);
        chk({tag, "_len_hi"}, d, (len >> 8) & 255);
        rd_byte(d, s);
        chk({tag, "_sof_lo"}, s, 0);
        chk({tag, "_len_lo"}, d, len & 255);
        for (int i = 0; i < len; i++) begin
            rd_byte(d, s);
            if (s) psof++;
            chk({tag, "_pay"}, d, (base + i) & 255);
        end
        chk({tag, "_pay_sof"}, psof, 0);
    endtask

    initial begin
        logic [7:0] got [0:4];
        logic       s_sof0;
        int         n, lc, seen;

        step(2);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_empty", txff_empty, 1);
        chk("rst_sof", txff_sof, 0);
        chk("rst_dout", txff_dout, 0);
        chk("rst_frames", frame_count, 0);
        chk("rst_drops", drop_count, 0);
        chk("rst_s_empty", s_txff_empty, 1);
        reset = 1'b0;
        step(1);
        chk("idle_wr_ready", wr_ready, 1);

        // 60-byte frame, store-and-forward then readout
        wr_frame(60, 8'h00);
        chk("sf_empty", txff_empty, 1);
        rd_frame(60, 8'h00, "f60");
        exp_frames++;
        chk("f60_frames", frame_count, ecnt(exp_frames));
        chk("f60_drained", txff_empty, 1);

        // single-byte frame: two length-write cycles with wr_ready low
        wr_byte(8'hA5, 1'b1, 1'b0);
        lc = 0;
        while (!wr_ready && lc < 10) begin
            lc++;
            step(1);
        end
        chk("f1_ready_low", lc, 2);
        rd_frame(1, 8'hA5, "f1");
        exp_frames++;

        // abort while idle does nothing
        wr_abort = 1'b1;
        step(1);
        wr_abort = 1'b0;
        step(2);
        chk("idle_abort_drops", drop_count, ecnt(exp_drops));
        chk("idle_abort_empty", txff_empty, 1);

        // max_len overflow drops, exact max_len passes
        max_len = 14'd64;
        wr_frame(65, 8'h00);
        exp_drops++;
        step(6);
        chk("ovf_empty", txff_empty, 1);
        chk("ovf_drops", drop_count, ecnt(exp_drops));
        wr_frame(64, 8'h40);
        rd_frame(64, 8'h40, "f64");
        exp_frames++;
        chk("f64_frames", frame_count, ecnt(exp_frames));
        max_len = 14'd2000;

        // abort with eof after 10 bytes, then a clean 20-byte frame
        for (int i = 0; i < 10; i++) wr_byte(8'(8'hC0 + i), 1'b0, 1'b0);
        wr_byte(8'hCA, 1'b1, 1'b1);
        exp_drops++;
        step(6);
        chk("abort_empty", txff_empty, 1);
        chk("abort_drops", drop_count, ecnt(exp_drops));
        wr_frame(20, 8'h60);
        rd_frame(20, 8'h60, "f20");
        exp_frames++;
        chk("f20_drained", txff_empty, 1);

        // two back-to-back 60-byte frames, reader holds rden high
        fork
            begin
                wr_frame(60, 8'h10);
                wr_frame(60, 8'h80);
            end
            begin
                int idx = 0, gaps = 0, sofs = 0, bad = 0, cyc = 0;
                int pos, fr, ev;
                txff_rden = 1'b1;
                while (idx < 124 && cyc < 3000) begin
                    if (!txff_empty) begin
                        pos = idx % 62;
                        fr  = idx / 62;
                        ev  = (pos == 0) ? 0 : (pos == 1) ? 60 : ((fr == 0 ? 8'h10 : 8'h80) + pos - 2);
                        if (txff_dout !== 8'(ev)) bad++;
                        if (txff_sof !== (pos == 0)) bad++;
                        if (txff_sof) sofs++;
                        idx++;
                    end else if (idx % 62 != 0) begin
                        gaps++;
                    end
                    step(1);
                    cyc++;
                end
                txff_rden = 1'b0;
                chk("b2b_bytes", idx, 124);
                chk("b2b_gaps", gaps, 0);
                chk("b2b_sofs", sofs, 2);
                chk("b2b_bad", bad, 0);
            end
        join
        exp_frames += 2;
        chk("b2b_frames", frame_count, ecnt(exp_frames));

        // AW=6 instance: 70 bytes overflow the buffer at byte 62
        s_txff_rden = 1'b1;
        seen = 0;
        for (int i = 1; i <= 70; i++) begin
            s_wr_byte(8'(i), i == 70);
            if (!s_txff_empty) seen++;
            if (i == 61) chk("s_drops_b61", s_drop_count, 0);
            if (i == 62) chk("s_drops_b62", s_drop_count, ecnt(1));
        end
        step(4);
        if (!s_txff_empty) seen++;
        chk("s_never_visible", seen, 0);
        chk("s_drops", s_drop_count, ecnt(1));
        chk("s_frames", s_frame_count, 0);
        s_wr_byte(8'h11, 1'b0);
        s_wr_byte(8'h22, 1'b0);
        s_wr_byte(8'h33, 1'b1);
        n = 0;
        s_sof0 = 1'b0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            if (!s_txff_empty) begin
                got[n] = s_txff_dout;
                if (n == 0) s_sof0 = s_txff_sof;
                n++;
            end
            step(1);
        end
        s_txff_rden = 1'b0;
        chk("s_after_n", n, 5);
        chk("s_after_sof", s_sof0, 1);
        chk("s_after_b0", got[0], 8'h00);
        chk("s_after_b1", got[1], 8'h03);
        chk("s_after_b2", got[2], 8'h11);
        chk("s_after_b4", got[4], 8'h33);
        chk("s_frames2", s_frame_count, ecnt(1));

        // reset with a committed frame and a partial frame pending
        wr_frame(10, 8'h20);
        for (int i = 0; i < 5; i++) wr_byte(8'(i), 1'b0, 1'b0);
        reset = 1'b1;
        step(2);
        chk("mid_rst_wr_ready", wr_ready, 0);
        reset = 1'b0;
        step(8);
        chk("mid_rst_empty", txff_empty, 1);
        chk("mid_rst_frames", frame_count, 0);
        chk("mid_rst_drops", drop_count, 0);
        chk("mid_rst_ready", wr_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running, required finished");
        $fatal(1, "timeout");
    end

endmodule
